tx_frame_ctrl: RTL and testbench

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

---
 rtl/tx_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// Frame controller: takes a 5-bit message and sequences a 9-bit serializer (load, 8 shifts, done, gap).
// Latency: handshake on N -> ld on N+1, first bit on N+2, frame_done on N+1+9*BIT_DIV.
// Backpressure: msg_ready only in IDLE; with TX_QUEUE_EN a one-entry holding register also accepts while busy.
// Optional feature macro: TX_QUEUE_EN (one-entry holding register between frames).
module tx_frame_ctrl #(
    parameter int BIT_DIV  = 4,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       msg_valid,
    input  logic [4:0] msg_data,
    output logic       msg_ready,
    output logic       ld,
    output logic       shift,
    output logic [4:0] msg_out,
    output logic       mod_en,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    // Divider terminal values; DIV_PREV is only reached when BIT_DIV >= 2.
    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [7:0] DIV_PREV = 8'(BIT_DIV - 2);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
    localparam bit         NO_GAP   = (GAP_BITS == 0);
    localparam bit         FAST     = (BIT_DIV == 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [3:0] gap_cnt;

    logic       bit_end;
    logic       send_end;
    logic       gap_end;
    logic       frame_end;
    logic       hs;
    logic       start_nxt;
    logic [4:0] start_dat;

    assign bit_end   = (div_cnt == DIV_LAST);
    assign send_end  = (state == SEND) && bit_end && (bit_idx == 4'd8);
    assign gap_end   = !NO_GAP && (state == GAP) && bit_end && (gap_cnt == GAP_LAST);
    assign frame_end = NO_GAP ? send_end : gap_end;
    assign hs        = msg_valid && msg_ready;

`ifdef TX_QUEUE_EN
    logic       hold_vld;
    logic [4:0] hold_dat;
    logic       hold_wr;

    // Ready while the holding slot is free, or in the cycle it is being drained.
    assign msg_ready = rst_n && (!hold_vld || frame_end);
    // Next frame starts from IDLE on a handshake, or back-to-back at frame end.
    assign start_nxt = ((state == IDLE) && hs) || (frame_end && (hold_vld || hs));
    assign start_dat = (frame_end && hold_vld) ? hold_dat : msg_data;
    // A message that cannot go straight into LOAD is parked in the holding slot.
    assign hold_wr   = hs && (state != IDLE) && !(frame_end && !hold_vld);

    // Holding slot: filled on a parked handshake, drained when the next frame loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (hold_wr) begin
            hold_vld <= 1'b1;
            hold_dat <= msg_data;
        end else if (frame_end && hold_vld) begin
            hold_vld <= 1'b0;
        end
    end
`else
    // Only an idle controller accepts; gating with rst_n keeps ready low during reset.
    assign msg_ready = rst_n && (state == IDLE);
    assign start_nxt = (state == IDLE) && hs;
    assign start_dat = msg_data;
`endif

    // Frame sequencer; every output is a flop loaded with its value for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            ld         <= 1'b0;
            shift      <= 1'b0;
            msg_out    <= '0;
            mod_en     <= 1'b0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ld         <= 1'b0;
            shift      <= 1'b0;
            frame_done <= 1'b0;
            msg_out    <= '0;
            case (state)
                IDLE: begin
                    if (start_nxt) begin
                        state   <= LOAD;
                        ld      <= 1'b1;
                        msg_out <= start_dat;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= SEND;
                    mod_en  <= 1'b1;
                    bit_idx <= '0;
                    div_cnt <= '0;
                    // With one cycle per bit the first SEND cycle already ends bit 0.
                    shift   <= FAST;
                end
                SEND: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == 4'd8) begin
                            mod_en  <= 1'b0;
                            bit_idx <= '0;
                            if (!NO_GAP) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else if (start_nxt) begin
                                state   <= LOAD;
                                ld      <= 1'b1;
                                msg_out <= start_dat;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            if (FAST) begin
                                shift      <= (bit_idx != 4'd7);
                                frame_done <= (bit_idx == 4'd7);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                        // Next cycle closes the current bit period.
                        if (div_cnt == DIV_PREV) begin
                            shift      <= (bit_idx != 4'd8);
                            frame_done <= (bit_idx == 4'd8);
                        end
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (gap_cnt == GAP_LAST) begin
                            if (start_nxt) begin
                                state   <= LOAD;
                                ld      <= 1'b1;
                                msg_out <= start_dat;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: instance A (BIT_DIV=4, GAP_BITS=2), instance B (BIT_DIV=1, GAP_BITS=0).
// Stimulus pushes expected ld/shift/frame_done events; per-instance monitors pop and compare.
// Back-to-back expectations follow TX_QUEUE_EN when the bench is built with it.
module tb_tx_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0] a_data = '0, b_data = '0;
    logic       a_ready, a_ld, a_shift, a_mod_en, a_busy, a_done;
    logic       b_ready, b_ld, b_shift, b_mod_en, b_busy, b_done;
    logic [4:0] a_msg_out, b_msg_out;
    logic [3:0] a_bit_idx, b_bit_idx;

    tx_frame_ctrl #(.BIT_DIV(4), .GAP_BITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .msg_valid(a_valid), .msg_data(a_data),
        .msg_ready(a_ready), .ld(a_ld), .shift(a_shift), .msg_out(a_msg_out),
        .mod_en(a_mod_en), .bit_idx(a_bit_idx), .busy(a_busy), .frame_done(a_done)
    );

    tx_frame_ctrl #(.BIT_DIV(1), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .msg_valid(b_valid), .msg_data(b_data),
        .msg_ready(b_ready), .ld(b_ld), .shift(b_shift), .msg_out(b_msg_out),
        .mod_en(b_mod_en), .bit_idx(b_bit_idx), .busy(b_busy), .frame_done(b_done)
    );

    // kind: 0 = ld, 1 = shift, 2 = frame_done
    typedef struct {
        int         kind;
        int         cyc;
        logic [4:0] dat;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input int which, input int ld_c, input int bd, input logic [4:0] d);
        ev_t e;
        e.kind = 0; e.cyc = ld_c; e.dat = d;
        if (which == 0) qa.push_back(e); else qb.push_back(e);
        for (int k = 0; k < 8; k++) begin
            e.kind = 1; e.cyc = ld_c + bd * (k + 1); e.dat = '0;
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
        e.kind = 2; e.cyc = ld_c + 9 * bd; e.dat = '0;
        if (which == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic pop_ev(input int which, input string nm, input int kind, input logic [4:0] d);
        ev_t e;
        int  n;
        n = (which == 0) ? qa.size() : qb.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event: kind %0d at cycle %0d, expected none", nm, kind, cyc);
        end else begin
            if (which == 0) e = qa.pop_front(); else e = qb.pop_front();
            chk({nm, " event kind"}, 32'(kind), 32'(e.kind));
            chk({nm, " event cycle"}, cyc, e.cyc);
            if (kind == 0) chk({nm, " msg_out at ld"}, 32'(d), 32'(e.dat));
        end
    endtask

    // Handshake: returns the cycle whose closing edge captured the message.
    task automatic send(input int which, input logic [4:0] d, output int t);
        logic rdy;
        if (which == 0) begin a_valid = 1'b1; a_data = d; end
        else begin b_valid = 1'b1; b_data = d; end
        t = -1;
        for (int i = 0; i < 200; i++) begin
            rdy = (which == 0) ? a_ready : b_ready;
            if (rdy) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t >= 0) @(posedge clk);
        #1;
        if (which == 0) a_valid = 1'b0; else b_valid = 1'b0;
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake timeout on instance %0d: got no msg_ready, expected one within 200 cycles", which);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int a_sh = 0;
    int b_sh = 0;

    // Monitor for instance A
    always @(negedge clk) begin
        if (rst_n) begin
            chk("A ld/shift exclusive", 32'(a_ld & a_shift), 0);
            if (a_ld) begin
                a_sh = 0;
                pop_ev(0, "A", 0, a_msg_out);
            end
            if (a_shift) begin
                chk("A bit_idx at shift", 32'(a_bit_idx), a_sh);
                a_sh++;
                pop_ev(0, "A", 1, '0);
            end
            if (a_done) begin
                chk("A shifts per frame", a_sh, 8);
                chk("A bit_idx at done", 32'(a_bit_idx), 8);
                chk("A mod_en at done", 32'(a_mod_en), 1);
                pop_ev(0, "A", 2, '0);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (rst_n) begin
            chk("B ld/shift exclusive", 32'(b_ld & b_shift), 0);
            if (b_ld) begin
                b_sh = 0;
                pop_ev(1, "B", 0, b_msg_out);
            end
            if (b_shift) begin
                chk("B bit_idx at shift", 32'(b_bit_idx), b_sh);
                b_sh++;
                pop_ev(1, "B", 1, '0);
            end
            if (b_done) begin
                chk("B shifts per frame", b_sh, 8);
                chk("B bit_idx at done", 32'(b_bit_idx), 8);
                pop_ev(1, "B", 2, '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish well before 200000 time units");
        $fatal(1);
    end

    initial begin
        int t1, t2, t3;

        // Reset state
        #12;
        chk("A outputs in reset", 32'({a_ld, a_shift, a_ready, a_mod_en, a_bit_idx, a_busy, a_done, a_msg_out}), 0);
        chk("B outputs in reset", 32'({b_ld, b_shift, b_ready, b_mod_en, b_bit_idx, b_busy, b_done, b_msg_out}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("A ready after reset", 32'(a_ready), 1);

        // Single frame, BIT_DIV=4, GAP_BITS=2
        send(0, 5'b10110, t1);
        push_frame(0, t1 + 1, 4, 5'b10110);
        wait_to(t1 + 45);
        chk("A busy in last gap cycle", 32'(a_busy), 1);
        wait_to(t1 + 46);
        chk("A busy after gap", 32'(a_busy), 0);
        chk("A ready after gap", 32'(a_ready), 1);
        wait_to(t1 + 50);

        // Second message offered during a frame
`ifdef TX_QUEUE_EN
        send(0, 5'b10001, t1);
        push_frame(0, t1 + 1, 4, 5'b10001);
        wait_to(t1 + 10);
        send(0, 5'b01110, t2);
        chk("A queued accept cycle", t2 - t1, 10);
        push_frame(0, t1 + 46, 4, 5'b01110);
        wait_to(t1 + 46);
        chk("A busy between queued frames", 32'(a_busy), 1);
        wait_to(t1 + 92);
        chk("A idle after queued frame", 32'(a_busy), 0);
`else
        send(0, 5'b10001, t1);
        push_frame(0, t1 + 1, 4, 5'b10001);
        send(0, 5'b01110, t2);
        chk("A second handshake cycle", t2 - t1, 46);
        push_frame(0, t2 + 1, 4, 5'b01110);
        wait_to(t2 + 46);
        chk("A idle after second frame", 32'(a_busy), 0);
`endif
        wait_to(cyc + 4);

        // Reset mid-SEND aborts the frame
        send(0, 5'b11011, t1);
        push_frame(0, t1 + 1, 4, 5'b11011);
`ifdef TX_QUEUE_EN
        wait_to(t1 + 10);
        send(0, 5'b00111, t3);
        chk("A held before reset", t3 - t1, 10);
`endif
        wait_to(t1 + 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("A outputs during mid-frame reset", 32'({a_ld, a_shift, a_ready, a_mod_en, a_bit_idx, a_busy, a_done, a_msg_out}), 0);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("A ready first cycle after release", 32'(a_ready), 1);
        chk("A busy after release", 32'(a_busy), 0);
        wait_to(cyc + 60);
        chk("A stays idle after abort", 32'(a_busy), 0);
        send(0, 5'b00101, t1);
        push_frame(0, t1 + 1, 4, 5'b00101);
        wait_to(t1 + 46);
        chk("A idle after recovery frame", 32'(a_busy), 0);

        // BIT_DIV=1, GAP_BITS=0
        send(1, 5'b01001, t1);
        push_frame(1, t1 + 1, 1, 5'b01001);
        wait_to(t1 + 11);
        chk("B ready after frame", 32'(b_ready), 1);
        chk("B busy after frame", 32'(b_busy), 0);
        wait_to(t1 + 14);
        send(1, 5'b11100, t1);
        push_frame(1, t1 + 1, 1, 5'b11100);
        send(1, 5'b00011, t2);
`ifdef TX_QUEUE_EN
        chk("B queued accept cycle", t2 - t1, 1);
        push_frame(1, t1 + 11, 1, 5'b00011);
        wait_to(t1 + 22);
`else
        chk("B second handshake cycle", t2 - t1, 11);
        push_frame(1, t2 + 1, 1, 5'b00011);
        wait_to(t2 + 11);
`endif
        chk("B idle after back-to-back", 32'(b_busy), 0);

        wait_to(cyc + 10);
        chk("A scoreboard drained", 32'(qa.size()), 0);
        chk("B scoreboard drained", 32'(qb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
